// File: rtl/pc_gen.sv
// Fetch-stage program counter with prioritised redirects, an EPC register,
// a one-entry pending-redirect buffer and a BOOT/RUN/HALT fetch-valid FSM.
module pc_gen #(
  parameter int                WIDTH      = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC  = 32'h0000_3000,
  parameter logic [WIDTH-1:0]  EXC_VEC    = 32'h0000_4180,
  parameter int                STEP       = 4,
  parameter int                ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             redir_en,
  input  logic [WIDTH-1:0] redir_pc,
  input  logic             exc_en,
  input  logic [WIDTH-1:0] exc_epc,
  input  logic             eret_en,
  input  logic             halt_req,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic             pend_valid,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = (WIDTH'(1) << ALIGN_BITS) - WIDTH'(1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc_nxt, epc_nxt, pend_pc, pend_pc_nxt;
  logic             pend_valid_nxt, misalign_nxt;
  logic [WIDTH-1:0] target;
  logic             load_target;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      epc        <= '0;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      epc        <= epc_nxt;
      pend_pc    <= pend_pc_nxt;
      pend_valid <= pend_valid_nxt;
      misalign   <= misalign_nxt;
    end
  end

  // A live redirect is preferred over the buffered one; both go through the
  // same alignment trap when actually applied.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    epc_nxt        = epc;
    pend_pc_nxt    = pend_pc;
    pend_valid_nxt = pend_valid;
    misalign_nxt   = 1'b0;
    target         = redir_en ? redir_pc : pend_pc;
    load_target    = 1'b0;

    unique case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (exc_en) begin
          pc_nxt         = EXC_VEC;
          epc_nxt        = exc_epc;
          pend_valid_nxt = 1'b0;
        end else if (eret_en) begin
          pc_nxt         = epc;
          pend_valid_nxt = 1'b0;
        end else if (stall) begin
          if (redir_en) begin
            pend_pc_nxt    = redir_pc;
            pend_valid_nxt = 1'b1;
          end
        end else if (halt_req) begin
          state_nxt = HALT;
        end else if (redir_en || pend_valid) begin
          load_target = 1'b1;
        end else begin
          pc_nxt = pc + WIDTH'(STEP);
        end

        if (load_target) begin
          pend_valid_nxt = 1'b0;
          if ((target & ALIGN_MASK) != '0) begin
            pc_nxt       = EXC_VEC;
            epc_nxt      = target;
            misalign_nxt = 1'b1;
          end else begin
            pc_nxt = target;
          end
        end
      end
      HALT: begin
        if (exc_en) begin
          pc_nxt         = EXC_VEC;
          epc_nxt        = exc_epc;
          pend_valid_nxt = 1'b0;
          state_nxt      = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Fetch-valid is a decode of the state register only, so no input reaches it combinationally.
  assign pc_valid = (state == RUN);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redir_en = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        exc_en = 1'b0;
  logic [31:0] exc_epc = '0;
  logic        eret_en = 1'b0;
  logic        halt_req = 1'b0;
  logic [31:0] pc, epc;
  logic        pc_valid, pend_valid, misalign;

  int checks = 0;
  int failures = 0;

  pc_gen #(
    .WIDTH(32), .RESET_VEC(32'h0000_3000), .EXC_VEC(32'h0000_4180),
    .STEP(4), .ALIGN_BITS(2)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .redir_en(redir_en),
    .redir_pc(redir_pc), .exc_en(exc_en), .exc_epc(exc_epc),
    .eret_en(eret_en), .halt_req(halt_req), .pc(pc), .pc_valid(pc_valid),
    .epc(epc), .pend_valid(pend_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Reference model: fetch mode as two flags, redirect buffer as value+flag.
  logic [31:0] m_pc = 32'h3000;
  logic [31:0] m_epc = '0;
  logic [31:0] m_pend = '0;
  logic        m_pend_v = 1'b0;
  logic        m_mis = 1'b0;
  logic        m_booting = 1'b1;
  logic        m_halted = 1'b0;

  function automatic void take_redirect(input logic [31:0] t);
    m_pend_v = 1'b0;
    if (t % 4 != 0) begin
      m_pc  = 32'h4180;
      m_epc = t;
      m_mis = 1'b1;
    end else begin
      m_pc = t;
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pc = 32'h3000; m_epc = '0; m_pend_v = 1'b0; m_mis = 1'b0;
      m_booting = 1'b1; m_halted = 1'b0;
    end else begin
      m_mis = 1'b0;
      if (m_booting) begin
        m_booting = 1'b0;
      end else if (m_halted) begin
        if (exc_en) begin
          m_halted = 1'b0; m_pc = 32'h4180; m_epc = exc_epc; m_pend_v = 1'b0;
        end
      end else if (exc_en) begin
        m_pc = 32'h4180; m_epc = exc_epc; m_pend_v = 1'b0;
      end else if (eret_en) begin
        m_pc = m_epc; m_pend_v = 1'b0;
      end else if (stall) begin
        if (redir_en) begin
          m_pend = redir_pc; m_pend_v = 1'b1;
        end
      end else if (halt_req) begin
        m_halted = 1'b1;
      end else if (redir_en) begin
        take_redirect(redir_pc);
      end else if (m_pend_v) begin
        take_redirect(m_pend);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    checkOutput("model_pc", pc, m_pc);
    checkOutput("model_pc_valid", 32'(pc_valid), 32'(!m_booting && !m_halted && reset));
    checkOutput("model_epc", epc, m_epc);
    checkOutput("model_pend_valid", 32'(pend_valid), 32'(m_pend_v));
    checkOutput("model_misalign", 32'(misalign), 32'(m_mis));
  end

  task automatic applyStimulus(input logic s, input logic re, input logic [31:0] rp,
                               input logic ee, input logic [31:0] ep, input logic er,
                               input logic hr);
    @(negedge clk);
    stall = s; redir_en = re; redir_pc = rp;
    exc_en = ee; exc_epc = ep; eret_en = er; halt_req = hr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin
    logic [31:0] t;
    repeat (3) @(posedge clk);
    #3;
    checkOutput("reset_pc", pc, 32'h3000);
    checkOutput("reset_valid", 32'(pc_valid), 32'h0);
    checkOutput("reset_epc", epc, 32'h0);
    checkOutput("reset_pend", 32'(pend_valid), 32'h0);
    checkOutput("reset_misalign", 32'(misalign), 32'h0);

    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("boot_valid", 32'(pc_valid), 32'h0);
    settle();
    checkOutput("first_fetch_pc", pc, 32'h3000);
    checkOutput("first_fetch_valid", 32'(pc_valid), 32'h1);
    settle();
    checkOutput("seq_3004", pc, 32'h3004);
    settle();
    checkOutput("seq_3008", pc, 32'h3008);
    settle();
    settle();
    checkOutput("seq_3010", pc, 32'h3010);

    // Redirect buffered during a three-cycle stall
    applyStimulus(1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    checkOutput("stall_hold_pc", pc, 32'h3010);
    checkOutput("stall_pend", 32'(pend_valid), 32'h1);
    idle();
    settle();
    checkOutput("pend_apply_pc", pc, 32'h3100);
    checkOutput("pend_cleared", 32'(pend_valid), 32'h0);
    settle();
    checkOutput("after_pend_pc", pc, 32'h3104);

    // Live redirect beats the buffered one
    applyStimulus(1'b1, 1'b1, 32'h3100, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    applyStimulus(1'b0, 1'b1, 32'h3200, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    checkOutput("live_wins_pc", pc, 32'h3200);
    checkOutput("live_wins_pend", 32'(pend_valid), 32'h0);

    // Exception overrides stall, then return
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h3020, 1'b0, 1'b0);
    settle();
    checkOutput("exc_pc", pc, 32'h4180);
    checkOutput("exc_epc", epc, 32'h3020);
    idle();
    settle();
    checkOutput("handler_step", pc, 32'h4184);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    settle();
    checkOutput("eret_pc", pc, 32'h3020);

    // Misaligned live redirect traps for one cycle
    applyStimulus(1'b0, 1'b1, 32'h3102, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    checkOutput("mis_pc", pc, 32'h4180);
    checkOutput("mis_epc", epc, 32'h3102);
    checkOutput("mis_pulse", 32'(misalign), 32'h1);
    idle();
    settle();
    checkOutput("mis_pulse_end", 32'(misalign), 32'h0);

    // Misaligned buffered redirect is only trapped when applied
    applyStimulus(1'b1, 1'b1, 32'h3006, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    checkOutput("mis_buffered_quiet", 32'(misalign), 32'h0);
    idle();
    settle();
    checkOutput("mis_pend_epc", epc, 32'h3006);
    checkOutput("mis_pend_pulse", 32'(misalign), 32'h1);

    // Wrap-around, then HALT
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0);
    settle();
    checkOutput("wrap_pre", pc, 32'hFFFF_FFFC);
    idle();
    settle();
    checkOutput("wrap_zero", pc, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    settle();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'(i % 2), 1'b1, 32'h5000, 1'b0, 32'h0, 1'(i % 3 == 0), 1'b1);
      settle();
      checkOutput("halt_pc_frozen", pc, 32'h0);
      checkOutput("halt_invalid", 32'(pc_valid), 32'h0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234, 1'b0, 1'b1);
    settle();
    checkOutput("halt_exit_pc", pc, 32'h4180);
    checkOutput("halt_exit_valid", 32'(pc_valid), 32'h1);
    checkOutput("halt_exit_epc", epc, 32'h1234);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    settle();
    idle();
    #3;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_pc", pc, 32'h3000);
    checkOutput("async_reset_epc", epc, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        @(negedge clk);
        #3;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end else begin
        t = $urandom;
        if ($urandom_range(0, 7) != 0) t[1:0] = 2'b00;
        applyStimulus($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, t,
                      $urandom_range(0, 99) < 3, $urandom & 32'hFFFF_FFFC,
                      $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2);
      end
    end
    idle();
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
